// File: rtl/logic_unit_mc_pkg.sv
// Shared types for the multicycle execution unit: opcode enum and FSM state encoding.
package logic_unit_pkg;

   typedef enum logic [3:0] {
      OP_ADD    = 4'd0,
      OP_SUB    = 4'd1,
      OP_AND    = 4'd2,
      OP_OR     = 4'd3,
      OP_XOR    = 4'd4,
      OP_SLT    = 4'd5,
      OP_SLTU   = 4'd6,
      OP_SLL    = 4'd7,
      OP_SRL    = 4'd8,
      OP_SRA    = 4'd9,
      OP_SLLV   = 4'd10,
      OP_SRLV   = 4'd11,
      OP_SRAV   = 4'd12,
      OP_PASS_A = 4'd13,
      OP_MUL    = 4'd14,
      OP_DIV    = 4'd15
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/logic_unit_mc_if.sv
// Issue/result bundle between the control unit (master) and the execution unit (slave).
interface logic_unit_mc_if #(parameter int WIDTH = 32);
   import logic_unit_pkg::*;

   logic                     start;
   op_t                      op;
   logic [WIDTH-1:0]         src_a;
   logic [WIDTH-1:0]         src_b;
   logic [$clog2(WIDTH)-1:0] shamt;
   logic                     busy;
   logic                     done;
   logic [WIDTH-1:0]         result;
   logic [WIDTH-1:0]         result_hi;
   logic                     overflow;
   logic                     zero;
   logic                     eq;
   logic                     gt;
   logic                     lt;
   logic                     div0;

   modport master (
      output start, op, src_a, src_b, shamt,
      input  busy, done, result, result_hi, overflow, zero, eq, gt, lt, div0
   );

   modport slave (
      input  start, op, src_a, src_b, shamt,
      output busy, done, result, result_hi, overflow, zero, eq, gt, lt, div0
   );

endinterface

// File: rtl/logic_unit_mc_muldiv_iter.sv
// WIDTH-step shift-add multiplier / restoring divider on operand magnitudes.
// Divider datapath present only when LOGIC_UNIT_DIV_EN is defined.
module muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
`ifdef LOGIC_UNIT_DIV_EN
   input  logic             i_is_div,
`endif
   input  logic             i_load,
   input  logic             i_step,
   input  logic [WIDTH-1:0] i_a_mag,
   input  logic [WIDTH-1:0] i_b_mag,
   output logic             o_last,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);
   localparam int SHW = $clog2(WIDTH);

   logic [WIDTH:0]   r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_mb;
   logic [SHW-1:0]   r_cnt;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_hi_n;
   logic [WIDTH-1:0] w_lo_n;
`ifdef LOGIC_UNIT_DIV_EN
   logic             r_div;
   logic [WIDTH:0]   w_sh;
   logic             w_ge;
`endif

   // o_hi/o_lo expose the post-step value so the top can capture on the last step edge
   always_comb begin
      w_sum  = r_hi + (r_lo[0] ? {1'b0, r_mb} : '0);
      w_hi_n = {1'b0, w_sum[WIDTH:1]};
      w_lo_n = {w_sum[0], r_lo[WIDTH-1:1]};
`ifdef LOGIC_UNIT_DIV_EN
      w_sh   = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
      w_ge   = (w_sh >= {1'b0, r_mb});
      if (r_div) begin
         w_hi_n = w_ge ? (w_sh - {1'b0, r_mb}) : w_sh;
         w_lo_n = {r_lo[WIDTH-2:0], w_ge};
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (i_load) begin
         r_hi  <= '0;
         r_lo  <= i_a_mag;
         r_mb  <= i_b_mag;
         r_cnt <= '0;
`ifdef LOGIC_UNIT_DIV_EN
         r_div <= i_is_div;
`endif
      end else if (i_step) begin
         r_hi  <= w_hi_n;
         r_lo  <= w_lo_n;
         r_cnt <= r_cnt + SHW'(1);
      end
   end

   assign o_last = (r_cnt == SHW'(WIDTH - 1));
   assign o_hi   = w_hi_n[WIDTH-1:0];
   assign o_lo   = w_lo_n;

endmodule

// File: rtl/logic_unit_mc.sv
// Multicycle execution unit: single-cycle ALU/shift/compare plus iterative MUL/DIV.
// Define LOGIC_UNIT_DIV_EN to build the signed divider; otherwise DIV returns zeros in one cycle.
module logic_unit_mc
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic              clk,
   input  logic              reset,
   logic_unit_mc_if.slave    bus
);
   localparam int SHW = $clog2(WIDTH);

   state_t           r_state;
   logic             r_busy, r_done;
   logic [WIDTH-1:0] r_result, r_result_hi;
   logic             r_ovf, r_zero, r_eq, r_gt, r_lt, r_div0;
   logic             r_eq_p0, r_gt_p0, r_lt_p0, r_neg_q;
`ifdef LOGIC_UNIT_DIV_EN
   logic             r_is_div, r_neg_r;
`endif

   logic [WIDTH-1:0]   w_a, w_b, w_sum, w_diff, w_res, w_res_hi, w_a_mag, w_b_mag;
   logic [WIDTH-1:0]   w_eng_hi, w_eng_lo, w_fin_lo, w_fin_hi;
   logic [2*WIDTH-1:0] w_prod;
   logic [SHW-1:0]     w_vamt;
   logic               w_ovf, w_div0, w_iter, w_lt_s, w_lt_u, w_last, w_load;

   assign w_a     = bus.src_a;
   assign w_b     = bus.src_b;
   assign w_vamt  = w_a[SHW-1:0];
   assign w_a_mag = w_a[WIDTH-1] ? -w_a : w_a;
   assign w_b_mag = w_b[WIDTH-1] ? -w_b : w_b;

   always_comb begin
      w_sum    = w_a + w_b;
      w_diff   = w_a - w_b;
      w_lt_s   = ($signed(w_a) < $signed(w_b));
      w_lt_u   = (w_a < w_b);
      w_res    = '0;
      w_res_hi = '0;
      w_ovf    = 1'b0;
      w_div0   = 1'b0;
      w_iter   = 1'b0;
      case (bus.op)
         OP_ADD:    begin
            w_res = w_sum;
            w_ovf = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
         end
         OP_SUB:    begin
            w_res = w_diff;
            w_ovf = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);
         end
         OP_AND:    w_res = w_a & w_b;
         OP_OR:     w_res = w_a | w_b;
         OP_XOR:    w_res = w_a ^ w_b;
         OP_SLT:    w_res = {{(WIDTH-1){1'b0}}, w_lt_s};
         OP_SLTU:   w_res = {{(WIDTH-1){1'b0}}, w_lt_u};
         OP_SLL:    w_res = w_b << bus.shamt;
         OP_SRL:    w_res = w_b >> bus.shamt;
         OP_SRA:    w_res = $unsigned($signed(w_b) >>> bus.shamt);
         OP_SLLV:   w_res = w_b << w_vamt;
         OP_SRLV:   w_res = w_b >> w_vamt;
         OP_SRAV:   w_res = $unsigned($signed(w_b) >>> w_vamt);
         OP_PASS_A: w_res = w_a;
         OP_MUL:    w_iter = 1'b1;
`ifdef LOGIC_UNIT_DIV_EN
         // Divide by zero bypasses the iteration entirely
         OP_DIV:    begin
            if (w_b == '0) begin
               w_res    = '1;
               w_res_hi = w_a;
               w_div0   = 1'b1;
            end else begin
               w_iter = 1'b1;
            end
         end
`endif
         default:   w_res = '0;
      endcase
   end

   assign w_load = (r_state == IDLE) && bus.start && w_iter;

   muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
      .clk     (clk),
`ifdef LOGIC_UNIT_DIV_EN
      .i_is_div(bus.op == OP_DIV),
`endif
      .i_load  (w_load),
      .i_step  (r_state == ITER),
      .i_a_mag (w_a_mag),
      .i_b_mag (w_b_mag),
      .o_last  (w_last),
      .o_hi    (w_eng_hi),
      .o_lo    (w_eng_lo)
   );

   // Sign fixup of the magnitude result from the engine
   always_comb begin
      w_prod   = r_neg_q ? -{w_eng_hi, w_eng_lo} : {w_eng_hi, w_eng_lo};
      w_fin_lo = w_prod[WIDTH-1:0];
      w_fin_hi = w_prod[2*WIDTH-1:WIDTH];
`ifdef LOGIC_UNIT_DIV_EN
      if (r_is_div) begin
         w_fin_lo = r_neg_q ? -w_eng_lo : w_eng_lo;
         w_fin_hi = r_neg_r ? -w_eng_hi : w_eng_hi;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_result    <= '0;
         r_result_hi <= '0;
         {r_ovf, r_zero, r_eq, r_gt, r_lt, r_div0} <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: if (bus.start) begin
               r_busy  <= 1'b1;
               r_eq_p0 <= (w_a == w_b);
               r_gt_p0 <= ($signed(w_a) > $signed(w_b));
               r_lt_p0 <= w_lt_s;
               r_neg_q <= w_a[WIDTH-1] ^ w_b[WIDTH-1];
`ifdef LOGIC_UNIT_DIV_EN
               r_neg_r  <= w_a[WIDTH-1];
               r_is_div <= (bus.op == OP_DIV);
`endif
               if (w_iter) begin
                  r_state <= ITER;
               end else begin
                  r_state     <= DONE;
                  r_done      <= 1'b1;
                  r_result    <= w_res;
                  r_result_hi <= w_res_hi;
                  r_ovf       <= w_ovf;
                  r_div0      <= w_div0;
                  r_zero      <= (w_res == '0);
                  r_eq        <= (w_a == w_b);
                  r_gt        <= ($signed(w_a) > $signed(w_b));
                  r_lt        <= w_lt_s;
               end
            end
            ITER: if (w_last) begin
               r_state     <= DONE;
               r_done      <= 1'b1;
               r_result    <= w_fin_lo;
               r_result_hi <= w_fin_hi;
               r_ovf       <= 1'b0;
               r_div0      <= 1'b0;
               r_zero      <= (w_fin_lo == '0);
               r_eq        <= r_eq_p0;
               r_gt        <= r_gt_p0;
               r_lt        <= r_lt_p0;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.result    = r_result;
   assign bus.result_hi = r_result_hi;
   assign bus.overflow  = r_ovf;
   assign bus.zero      = r_zero;
   assign bus.eq        = r_eq;
   assign bus.gt        = r_gt;
   assign bus.lt        = r_lt;
   assign bus.div0      = r_div0;

endmodule

// File: tb/tb_logic_unit_mc.sv
// Randomized bench for logic_unit_mc with a per-cycle arithmetic reference model.
module tb_logic_unit_mc;
   import logic_unit_pkg::*;

   typedef struct packed {
      logic [31:0] res;
      logic [31:0] hi;
      logic        ovf, zero, eq, gt, lt, div0;
   } exp_t;

   localparam longint SMAX = 64'sh7FFFFFFF;
   localparam longint SMIN = -64'sh80000000;

   logic clk, reset;
   logic_unit_mc_if #(.WIDTH(32)) bus ();

   logic_unit_mc #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

   int   n_checks = 0;
   int   n_err    = 0;
   int   cyc;
   int   m_busy_end, m_done_cyc;
   logic chk_en;
   exp_t cur, pend;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, b,
                                  input logic [4:0] sh, output int lat);
      exp_t        e;
      longint      sa, sb, t;
      logic [63:0] p;
      logic [4:0]  va;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      va  = a[4:0];
      e   = '0;
      lat = 1;
      case (op)
         4'd0:  begin t = sa + sb; p = t; e.res = p[31:0]; e.ovf = (t > SMAX) || (t < SMIN); end
         4'd1:  begin t = sa - sb; p = t; e.res = p[31:0]; e.ovf = (t > SMAX) || (t < SMIN); end
         4'd2:  e.res = a & b;
         4'd3:  e.res = a | b;
         4'd4:  e.res = a ^ b;
         4'd5:  e.res = (sa < sb) ? 32'd1 : 32'd0;
         4'd6:  e.res = (a < b) ? 32'd1 : 32'd0;
         4'd7:  e.res = b << sh;
         4'd8:  e.res = b >> sh;
         4'd9:  begin p = sb >>> sh; e.res = p[31:0]; end
         4'd10: e.res = b << va;
         4'd11: e.res = b >> va;
         4'd12: begin p = sb >>> va; e.res = p[31:0]; end
         4'd13: e.res = a;
         4'd14: begin p = sa * sb; e.res = p[31:0]; e.hi = p[63:32]; lat = 33; end
         default: begin
`ifdef LOGIC_UNIT_DIV_EN
            if (b == 32'd0) begin
               e.res = 32'hFFFFFFFF; e.hi = a; e.div0 = 1'b1;
            end else begin
               p = sa / sb; e.res = p[31:0];
               p = sa % sb; e.hi  = p[31:0];
               lat = 33;
            end
`else
            e.res = 32'd0;
`endif
         end
      endcase
      e.zero = (e.res == 32'd0);
      e.eq   = (sa == sb);
      e.gt   = (sa > sb);
      e.lt   = (sa < sb);
      return e;
   endfunction

   // Reference timeline: outputs change at the edge the model's done cycle lands on
   initial begin
      int lat;
      cyc = 0; m_busy_end = -1; m_done_cyc = -1; chk_en = 1'b0;
      cur = '0; pend = '0;
      forever begin
         @(posedge clk);
         cyc++;
         if (reset) begin
            cur = '0; m_done_cyc = -1; m_busy_end = cyc - 1; chk_en = 1'b1;
         end else begin
            if (bus.start && (m_busy_end < cyc - 1)) begin
               pend = model(bus.op, bus.src_a, bus.src_b, bus.shamt, lat);
               m_done_cyc = cyc + lat - 1;
               m_busy_end = m_done_cyc;
            end
            if (m_done_cyc == cyc) cur = pend;
         end
      end
   end

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic tick();
      exp_t got;
      @(negedge clk);
      if (chk_en) begin
         got = {bus.result, bus.result_hi, bus.overflow, bus.zero,
                bus.eq, bus.gt, bus.lt, bus.div0};
         check("ctrl_busy_done", {bus.busy, bus.done}, {cyc <= m_busy_end, cyc == m_done_cyc});
         check("outputs", got, cur);
      end
   endtask

   task automatic do_op(input logic [3:0] op, input logic [31:0] a, b,
                        input logic [4:0] sh, output int lat);
      int n;
      n = 0;
      while (bus.busy && n < 60) begin tick(); n++; end
      bus.op = op_t'(op); bus.src_a = a; bus.src_b = b; bus.shamt = sh; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      n = 1;
      while (!bus.done && n < 60) begin
         if ($urandom_range(0, 3) == 0) begin
            bus.start = 1'b1;
            bus.op    = op_t'(4'($urandom_range(0, 15)));
            bus.src_a = $urandom; bus.src_b = $urandom; bus.shamt = 5'($urandom);
         end else begin
            bus.start = 1'b0;
         end
         tick();
         n++;
      end
      bus.start = 1'b0;
      if (!bus.done) begin
         n_checks++; n_err++;
         $display("FAIL done_timeout: no done after %0d cycles, required within 33", n);
      end
      lat = n;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return 32'h7FFFFFFF;
         5: return 32'($signed(6'($urandom)));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int lat;
      reset = 1'b1; bus.start = 1'b0; bus.op = OP_ADD;
      bus.src_a = '0; bus.src_b = '0; bus.shamt = '0;
      repeat (3) tick();
      check("reset_state", {bus.busy, bus.done, bus.result, bus.result_hi}, '0);
      reset = 1'b0;
      tick();

      do_op(4'd0, 32'h7FFFFFFF, 32'd1, 5'd0, lat);
      check("add_latency", lat, 1);
      check("add_result", bus.result, 32'h80000000);
      check("add_ovf_zero", {bus.overflow, bus.zero}, 2'b10);

      do_op(4'd1, 32'd5, 32'd5, 5'd0, lat);
      check("sub_zero_eq", {bus.zero, bus.eq, bus.overflow}, 3'b110);

      do_op(4'd9, 32'd0, 32'h80000000, 5'd31, lat);
      check("sra_result", bus.result, 32'hFFFFFFFF);

      do_op(4'd11, 32'd4, 32'h000000F0, 5'd0, lat);
      check("srlv_result", bus.result, 32'h0000000F);

      do_op(4'd5, 32'h80000000, 32'd1, 5'd0, lat);
      check("slt_result", bus.result, 32'd1);
      do_op(4'd6, 32'h80000000, 32'd1, 5'd0, lat);
      check("sltu_result", bus.result, 32'd0);

      do_op(4'd14, 32'hFFFFFFFD, 32'd7, 5'd0, lat);
      check("mul_latency", lat, 33);
      check("mul_product", {bus.result_hi, bus.result}, 64'hFFFFFFFF_FFFFFFEB);
      check("mul_model", {cur.hi, cur.res}, 64'hFFFFFFFF_FFFFFFEB);

      do_op(4'd14, 32'h80000000, 32'h80000000, 5'd0, lat);
      check("mul_min_min", {bus.result_hi, bus.result, bus.overflow}, {64'h40000000_00000000, 1'b0});

      do_op(4'd15, 32'hFFFFFFF9, 32'd2, 5'd0, lat);
`ifdef LOGIC_UNIT_DIV_EN
      check("div_result", {bus.result_hi, bus.result}, 64'hFFFFFFFF_FFFFFFFD);
      check("div_model", {cur.hi, cur.res}, 64'hFFFFFFFF_FFFFFFFD);
`else
      check("div_disabled", {bus.result_hi, bus.result, bus.div0}, 65'd0);
      check("div_dis_latency", lat, 1);
`endif
      do_op(4'd15, 32'd9, 32'd0, 5'd0, lat);
      check("div0_latency", lat, 1);
`ifdef LOGIC_UNIT_DIV_EN
      check("div0_result", {bus.div0, bus.result, bus.result_hi}, {1'b1, 32'hFFFFFFFF, 32'd9});
`else
      check("div0_disabled", {bus.div0, bus.result}, 33'd0);
`endif

      // Abort a multiply partway through its iterations
      while (bus.busy) tick();
      bus.op = OP_MUL; bus.src_a = 32'd12345; bus.src_b = 32'd678; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (5) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("reset_midop", {bus.busy, bus.done, bus.result}, 34'd0);
      repeat (40) tick();

      for (int i = 0; i < 250; i++) begin
         do_op(4'($urandom_range(0, 15)), pick(), pick(), 5'($urandom), lat);
      end
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
